uart_reg_arb: RTL and testbench
===============================

// Module: uart_reg_arb
// PURPOSE
//  Round-robin arbiter sharing the single uart_top register port (reg_we/waddr/wdata,
//  reg_raddr/rdata) between N_REQ requesters, e.g. host bus bridge and TX streamer.
//  Serialises requests so only one register access reaches the UART per grant.
//  Keeps reg_raddr_o parked on a side-effect-free address so RX FIFO pops only on granted reads.
// PARAMETERS
//  N_REQ       2      number of requesters (2..8)
//  IDLE_RADDR  5'h00  address driven on reg_raddr_o when no read is issued (must not pop RX)
// PORTS
//  clk_i        in   1          clock
//  reset_i      in   1          asynchronous, active-high reset
//  req_valid_i  in   N_REQ      request pending, one bit per requester
//  req_we_i     in   N_REQ      1=write, 0=read, per requester
//  req_addr_i   in   5*N_REQ    register address, requester k at [5k+4:5k]
//  req_wdata_i  in   32*N_REQ   write data, requester k at [32k+31:32k]
//  req_ready_o  out  N_REQ      one-cycle accept pulse to granted requester
//  rsp_valid_o  out  N_REQ      one-cycle read-response pulse to requester
//  rsp_rdata_o  out  32         read data, valid only while any rsp_valid_o bit is high
//  reg_we_o     out  1          to uart_top reg_we_i
//  reg_waddr_o  out  5          to uart_top reg_waddr_i
//  reg_wdata_o  out  32         to uart_top reg_wdata_i
//  reg_raddr_o  out  5          to uart_top reg_raddr_i
//  reg_rdata_i  in   32         from uart_top reg_rdata_o (combinational from reg_raddr_o)
// BEHAVIOUR
//  Reset: state=IDLE, last-served ptr=N_REQ-1 (requester 0 wins first), all outputs 0,
//   except reg_raddr_o=IDLE_RADDR. Async assert; in-flight op dropped, no rsp issued.
//  Requester rule: hold req_valid/we/addr/wdata stable until req_ready_o pulse.
//   Dropping valid before ready is legal only if no grant was latched.
//  FSM IDLE: if any req_valid_i, pick first set bit searching from ptr+1 modulo N_REQ.
//   Latch win index, we, addr, wdata; update ptr=win; -> ISSUE. No valid: stay IDLE.
//  FSM ISSUE (exactly 1 cycle): req_ready_o[win]=1.
//   Write: reg_we_o=1, reg_waddr_o/reg_wdata_o=latched values; -> IDLE.
//   Read: reg_raddr_o=latched addr; capture reg_rdata_i into rdata reg; -> RESP.
//  FSM RESP (1 cycle): rsp_valid_o[win]=1, rsp_rdata_o=captured data; -> IDLE.
//   reg_raddr_o=IDLE_RADDR.
//  reg_raddr_o equals a requester address only in ISSUE of a read, else IDLE_RADDR.
//   Exactly one RX pop per granted RX-data read.
//  reg_we_o high only in ISSUE of a write; never high in IDLE/RESP.
//  Latency, req_valid to accept: 1 cycle min (valid seen in IDLE at N, ready at N+1).
//   Read data at N+2. Throughput: write 1 per 2 cycles, read 1 per 3 cycles.
//  Fairness: a continuously requesting agent waits at most N_REQ-1 grants.
//  Simultaneous requests: resolved only by round-robin ptr; same-cycle new requests
//   during ISSUE/RESP wait for next IDLE.
//  Outputs registered except reg_raddr_o/reg_we_o/reg_waddr_o/reg_wdata_o,
//   which are registered decode of state and latched values.
//  No address checking; writes to RO addresses passed through unchanged.
// TESTING
//  Reset, then req0 write addr 5'h01 data 32'h0000_0364 ->
//   reg_we_o=1 for 1 cycle, waddr=01, wdata=364; req_ready_o=2'b01 same cycle.
//  req1 read addr 5'h03, reg_rdata_i=32'h0000_0041 ->
//   reg_raddr_o=03 only in ISSUE; rsp_valid_o=2'b10 next cycle, rsp_rdata_o=32'h41.
//  Both request at once from reset -> grants in order 0,1,0,1 over 4 ops;
//   never same requester twice while other pending.
//  Idle for 20 cycles -> reg_raddr_o=IDLE_RADDR and reg_we_o=0 every cycle;
//   RX FIFO level unchanged.
//  Assert reset_i during ISSUE of a read -> all outputs 0 immediately, no rsp_valid_o;
//   next grant after release goes to requester 0.
//  N_REQ=4, all four requesting for 12 ops -> each requester granted exactly 3 times,
//   max wait 3 grants.

Source files
------------

// File: rtl/uart_reg_arb.sv
// uart_reg_arb: round-robin arbiter sharing one uart_top register port between N_REQ requesters.
module uart_reg_arb #(
  parameter int         N_REQ      = 2,
  parameter logic [4:0] IDLE_RADDR = 5'h00
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [N_REQ-1:0]     req_we_i,
  input  logic [5*N_REQ-1:0]   req_addr_i,
  input  logic [32*N_REQ-1:0]  req_wdata_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     rsp_valid_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 reg_we_o,
  output logic [4:0]           reg_waddr_o,
  output logic [31:0]          reg_wdata_o,
  output logic [4:0]           reg_raddr_o,
  input  logic [31:0]          reg_rdata_i
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, pick;
  logic          we_q, we_d, found;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && req_valid_i[(int'(ptr_q) + i) % N_REQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (found) begin
        win_d   = pick;
        ptr_d   = pick;
        we_d    = req_we_i[pick];
        addr_d  = req_addr_i[5*int'(pick) +: 5];
        wdata_d = req_wdata_i[32*int'(pick) +: 32];
        state_d = ISSUE;
      end
      ISSUE: begin
        rdata_d = we_q ? rdata_q : reg_rdata_i;
        state_d = we_q ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N_REQ - 1);
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // Read address leaves IDLE_RADDR only during a granted read, so the RX FIFO pops once per grant.
  assign req_ready_o = (state_q == ISSUE) ? (N_REQ'(1) << win_q) : '0;
  assign rsp_valid_o = (state_q == RESP) ? (N_REQ'(1) << win_q) : '0;
  assign rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
  assign reg_we_o    = (state_q == ISSUE) && we_q;
  assign reg_waddr_o = reg_we_o ? addr_q : '0;
  assign reg_wdata_o = reg_we_o ? wdata_q : '0;
  assign reg_raddr_o = ((state_q == ISSUE) && !we_q) ? addr_q : IDLE_RADDR;
endmodule

// File: tb/tb_uart_reg_arb.sv
// tb_uart_reg_arb: directed checks of uart_reg_arb with N_REQ=2 and N_REQ=4 instances.
module tb_uart_reg_arb;
  logic         clk = 1'b0, reset = 1'b1;
  logic [1:0]   v2 = '0, we2 = '0, rdy2, rsp2;
  logic [9:0]   addr2 = '0;
  logic [63:0]  wdata2 = '0;
  logic [31:0]  rsp_rdata2, wd_o, rd_i;
  logic         we_o;
  logic [4:0]   wa_o, ra_o;
  logic [3:0]   v4 = '0, we4 = '0, rdy4, rsp4;
  logic [19:0]  addr4 = '0;
  logic [127:0] wdata4 = '0;
  logic [31:0]  rsp_rdata4, wd4_o, zero32 = '0;
  logic         we4_o;
  logic [4:0]   wa4_o, ra4_o;
  int           tests = 0, fails = 0, pops = 0;
  int           cnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  assign rd_i = (ra_o == 5'h03) ? 32'h0000_0041 : {27'h0, ra_o} ^ 32'hA500_0000;

  always @(posedge clk) if (ra_o != 5'h00) pops++;

  uart_reg_arb #(.N_REQ(2), .IDLE_RADDR(5'h00)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(v2), .req_we_i(we2),
    .req_addr_i(addr2), .req_wdata_i(wdata2), .req_ready_o(rdy2),
    .rsp_valid_o(rsp2), .rsp_rdata_o(rsp_rdata2), .reg_we_o(we_o),
    .reg_waddr_o(wa_o), .reg_wdata_o(wd_o), .reg_raddr_o(ra_o), .reg_rdata_i(rd_i));

  uart_reg_arb #(.N_REQ(4), .IDLE_RADDR(5'h00)) dut4 (
    .clk_i(clk), .reset_i(reset), .req_valid_i(v4), .req_we_i(we4),
    .req_addr_i(addr4), .req_wdata_i(wdata4), .req_ready_o(rdy4),
    .rsp_valid_o(rsp4), .rsp_rdata_o(rsp_rdata4), .reg_we_o(we4_o),
    .reg_waddr_o(wa4_o), .reg_wdata_o(wd4_o), .reg_raddr_o(ra4_o), .reg_rdata_i(zero32));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk("rst_ready", 32'(rdy2), 32'h0);
    chk("rst_rsp", 32'(rsp2), 32'h0);
    chk("rst_we", 32'(we_o), 32'h0);
    chk("rst_raddr", 32'(ra_o), 32'h0);
    chk("rst_rdata", rsp_rdata2, 32'h0);
    reset = 1'b0;
    v2 = 2'b01; we2 = 2'b01; addr2[4:0] = 5'h01; wdata2[31:0] = 32'h0000_0364;
    step();
    chk("wr_ready", 32'(rdy2), 32'h1);
    chk("wr_we", 32'(we_o), 32'h1);
    chk("wr_waddr", 32'(wa_o), 32'h01);
    chk("wr_wdata", wd_o, 32'h0000_0364);
    chk("wr_raddr", 32'(ra_o), 32'h0);
    v2 = 2'b00;
    step();
    chk("wr_we_off", 32'(we_o), 32'h0);
    chk("wr_ready_off", 32'(rdy2), 32'h0);
    v2 = 2'b10; we2 = 2'b00; addr2[9:5] = 5'h03;
    step();
    chk("rd_raddr", 32'(ra_o), 32'h03);
    chk("rd_ready", 32'(rdy2), 32'h2);
    chk("rd_rsp_early", 32'(rsp2), 32'h0);
    chk("rd_we", 32'(we_o), 32'h0);
    v2 = 2'b00;
    step();
    chk("rd_rsp", 32'(rsp2), 32'h2);
    chk("rd_rdata", rsp_rdata2, 32'h0000_0041);
    chk("rd_raddr_park", 32'(ra_o), 32'h0);
    step();
    chk("rd_rsp_off", 32'(rsp2), 32'h0);
    chk("rd_pops", 32'(pops), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    v2 = 2'b11; we2 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr_grant%0d", k), 32'(rdy2), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      chk($sformatf("rr_gap%0d", k), 32'(rdy2), 32'h0);
    end
    v2 = 2'b00;
    step();
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("idle_raddr%0d", k), 32'(ra_o), 32'h0);
      chk($sformatf("idle_we%0d", k), 32'(we_o), 32'h0);
    end
    chk("idle_pops", 32'(pops), 32'd1);
    v2 = 2'b01; we2 = 2'b00; addr2[4:0] = 5'h03;
    step();
    chk("ar_raddr", 32'(ra_o), 32'h03);
    chk("ar_ready", 32'(rdy2), 32'h1);
    reset = 1'b1;
    #1;
    chk("ar_ready_rst", 32'(rdy2), 32'h0);
    chk("ar_raddr_rst", 32'(ra_o), 32'h0);
    chk("ar_we_rst", 32'(we_o), 32'h0);
    step();
    chk("ar_no_rsp", 32'(rsp2), 32'h0);
    v2 = 2'b11; we2 = 2'b11;
    reset = 1'b0;
    step();
    chk("ar_next_grant", 32'(rdy2), 32'h1);
    v2 = 2'b00;
    step();
    chk("ar_pops", 32'(pops), 32'd1);
    v4 = 4'hF; we4 = 4'hF;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("n4_grant%0d", k), 32'(rdy4), 32'(4'b0001 << (k % 4)));
      for (int j = 0; j < 4; j++) if (rdy4[j]) cnt[j]++;
      step();
      chk($sformatf("n4_gap%0d", k), 32'(rdy4), 32'h0);
    end
    v4 = 4'h0;
    for (int j = 0; j < 4; j++) chk($sformatf("n4_count%0d", j), 32'(cnt[j]), 32'd3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
